// File: rtl/aes_bus_pkg.sv
// Shared types and sizes for the AES bus word/block bridge.
package aes_bus_pkg;
  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int BLOCK_W = WORD_W * WORDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_CORE,
    S_UNLOAD
  } state_t;

  typedef logic [0:WORD_W-1]  word_t;
  typedef logic [0:BLOCK_W-1] block_t;
endpackage

// File: rtl/aes_word_packer.sv
// Four-word block register with saturating word counter and valid flag.
module aes_word_packer
  import aes_bus_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic          i_first,
  input  logic          i_vclr,
  input  logic [0:31]   i_din,
  output logic [0:127]  o_blk,
  output logic          o_valid
);

  logic [2:0] r_cnt;
  block_t     r_blk;
  logic       r_valid;

  logic [1:0] w_idx;
  logic       w_take;

  // A first word always restarts at word 0; otherwise stop at four.
  assign w_idx  = i_first ? 2'd0 : r_cnt[1:0];
  assign w_take = i_wr & (i_first | (r_cnt != 3'd4));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 3'd0;
      r_blk   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_blk[{w_idx, 5'd0} +: WORD_W] <= i_din;
        r_cnt <= {1'b0, w_idx} + 3'd1;
      end
      if (i_wr & i_first)
        r_valid <= 1'b0;
      else if (w_take & (w_idx == 2'd3))
        r_valid <= 1'b1;
      else if (i_vclr)
        r_valid <= 1'b0;
    end
  end

  assign o_blk   = r_blk;
  assign o_valid = r_valid;

endmodule

// File: rtl/aes_bus_buffer.sv
// Bus-to-AES bridge: packs bus words into blocks, launches the core,
// and streams the captured result back as four registered words.
module aes_bus_buffer
  import aes_bus_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          Initiate,
  input  logic          Read_or_Write,
  input  logic          Adress,
  input  logic          SelCypher,
  input  logic          Start,
  input  logic [0:31]   DATA_IN,
  output logic [0:31]   DATA_OUT,
  output logic          DATA_OE,
  output logic [0:127]  msg_block,
  output logic [0:127]  key_block,
  output logic          core_start,
  output logic          core_cypher,
  input  logic          core_done,
  input  logic [0:127]  core_result,
  output logic          busy,
  output logic          result_valid
);

  state_t     r_state, w_state_nx;
  logic       r_addr, w_addr_nx;
  logic       r_start, w_start_nx;
  logic       r_cypher, w_cypher_nx;
  logic       r_rv, w_rv_nx;
  logic       r_oe, w_oe_nx;
  word_t      r_dout, w_dout_nx;
  block_t     r_result, w_result_nx;
  logic [2:0] r_idx, w_idx_nx;

  logic       w_wr, w_first, w_launch;
  logic       w_msg_valid, w_key_valid;
  block_t     w_msg_blk, w_key_blk;

  aes_word_packer u_msg (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_wr    (w_wr & ~r_addr_sel()),
    .i_first (w_first),
    .i_vclr  (w_launch),
    .i_din   (DATA_IN),
    .o_blk   (w_msg_blk),
    .o_valid (w_msg_valid)
  );

  aes_word_packer u_key (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_wr    (w_wr & r_addr_sel()),
    .i_first (w_first),
    .i_vclr  (1'b0),
    .i_din   (DATA_IN),
    .o_blk   (w_key_blk),
    .o_valid (w_key_valid)
  );

  function automatic logic r_addr_sel();
    return Adress;
  endfunction

  always_comb begin
    w_state_nx  = r_state;
    w_addr_nx   = r_addr;
    w_start_nx  = 1'b0;
    w_cypher_nx = r_cypher;
    w_rv_nx     = r_rv;
    w_oe_nx     = 1'b0;
    w_dout_nx   = '0;
    w_result_nx = r_result;
    w_idx_nx    = r_idx;
    w_wr        = 1'b0;
    w_first     = 1'b0;
    w_launch    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Initiate & Read_or_Write) begin
          w_wr       = 1'b1;
          w_first    = 1'b1;
          w_addr_nx  = Adress;
          w_state_nx = S_LOAD;
        end else if (Initiate & r_rv) begin
          w_oe_nx    = 1'b1;
          w_dout_nx  = r_result[0 +: WORD_W];
          w_idx_nx   = 3'd1;
          w_state_nx = S_UNLOAD;
        end else if (Start & ~Initiate &
                     w_msg_valid & w_key_valid) begin
          w_launch    = 1'b1;
          w_start_nx  = 1'b1;
          w_cypher_nx = SelCypher;
          w_state_nx  = S_WAIT_CORE;
        end
      end
      S_LOAD: begin
        if (Initiate & Read_or_Write) begin
          w_wr      = 1'b1;
          w_first   = (Adress != r_addr);
          w_addr_nx = Adress;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT_CORE: begin
        if (core_done) begin
          w_result_nx = core_result;
          w_rv_nx     = 1'b1;
          w_state_nx  = S_IDLE;
        end
      end
      S_UNLOAD: begin
        // Completion wins once all four words have been shown.
        if (r_idx == 3'd4) begin
          w_rv_nx    = 1'b0;
          w_state_nx = S_IDLE;
        end else if (Initiate & ~Read_or_Write) begin
          w_oe_nx   = 1'b1;
          w_dout_nx = r_result[{r_idx[1:0], 5'd0} +: WORD_W];
          w_idx_nx  = r_idx + 3'd1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_addr   <= 1'b0;
      r_start  <= 1'b0;
      r_cypher <= 1'b0;
      r_rv     <= 1'b0;
      r_oe     <= 1'b0;
      r_dout   <= '0;
      r_result <= '0;
      r_idx    <= 3'd0;
    end else begin
      r_state  <= w_state_nx;
      r_addr   <= w_addr_nx;
      r_start  <= w_start_nx;
      r_cypher <= w_cypher_nx;
      r_rv     <= w_rv_nx;
      r_oe     <= w_oe_nx;
      r_dout   <= w_dout_nx;
      r_result <= w_result_nx;
      r_idx    <= w_idx_nx;
    end
  end

  assign DATA_OUT     = r_dout;
  assign DATA_OE      = r_oe;
  assign msg_block    = w_msg_blk;
  assign key_block    = w_key_blk;
  assign core_start   = r_start;
  assign core_cypher  = r_cypher;
  assign busy         = (r_state == S_WAIT_CORE);
  assign result_valid = r_rv;

endmodule

// File: tb/tb_aes_bus_buffer.sv
// Scoreboard bench for aes_bus_buffer: launches and read words are
// queued by the stimulus and matched by an independent monitor.
module tb_aes_bus_buffer;
  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         Initiate, Read_or_Write, Adress;
  logic         SelCypher, Start;
  logic [0:31]  DATA_IN;
  logic [0:31]  DATA_OUT;
  logic         DATA_OE;
  logic [0:127] msg_block, key_block;
  logic         core_start, core_cypher;
  logic         core_done;
  logic [0:127] core_result;
  logic         busy, result_valid;

  aes_bus_buffer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .Initiate(Initiate), .Read_or_Write(Read_or_Write),
    .Adress(Adress), .SelCypher(SelCypher), .Start(Start),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .msg_block(msg_block), .key_block(key_block),
    .core_start(core_start), .core_cypher(core_cypher),
    .core_done(core_done), .core_result(core_result),
    .busy(busy), .result_valid(result_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         cy;
    logic [0:127] m;
    logic [0:127] k;
  } start_t;

  start_t      q_start[$];
  logic [0:31] q_word[$];
  int n_chk  = 0;
  int n_fail = 0;
  logic prev_start = 1'b0;

  task automatic check(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents output.
  always @(negedge CLK) begin
    if (core_start) begin
      if (prev_start)
        check("start_one_cycle", 128'd1, 128'd0);
      if (q_start.size() == 0) begin
        check("unexpected_start", 128'd1, 128'd0);
      end else begin
        start_t e;
        e = q_start.pop_front();
        check("core_cypher", core_cypher, e.cy);
        check("launch_msg", msg_block, e.m);
        check("launch_key", key_block, e.k);
        check("busy_at_start", busy, 1'b1);
      end
    end
    prev_start = core_start;
    if (DATA_OE) begin
      if (q_word.size() == 0)
        check("unexpected_oe", 128'd1, 128'd0);
      else
        check("data_out", DATA_OUT, q_word.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_words(input logic a, input logic [31:0] w[]);
    foreach (w[i]) begin
      Initiate = 1'b1; Read_or_Write = 1'b1;
      Adress = a; DATA_IN = w[i];
      tick();
    end
    Initiate = 1'b0; Read_or_Write = 1'b0;
    tick();
  endtask

  task automatic launch(input logic cy);
    SelCypher = cy; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
  endtask

  task automatic finish_core(input logic [0:127] r);
    core_result = r; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
  endtask

  task automatic read(input int cycles);
    Initiate = 1'b1; Read_or_Write = 1'b0;
    repeat (cycles) tick();
    Initiate = 1'b0;
    tick();
  endtask

  task automatic exp_words(input logic [0:127] r, input int n);
    for (int i = 0; i < n; i++)
      q_word.push_back(r[32*i +: 32]);
  endtask

  logic [0:127] MSG1 = 128'h0123456789abcdeffedcba9876543210;
  logic [0:127] KEY1 = 128'habcdefab123456789abcdef00f1e2d3c;
  logic [0:127] MSG2 = 128'h11111111222222223333333344444444;
  logic [0:127] RES1 = 128'h00112233445566778899aabbccddeeff;
  logic [0:127] RES2 = 128'hcafef00ddeadbeef0badf00d55aa55aa;

  initial begin
    RESET_N = 1'b0; Initiate = 1'b0; Read_or_Write = 1'b0;
    Adress = 1'b0; SelCypher = 1'b0; Start = 1'b0;
    DATA_IN = '0; core_done = 1'b0; core_result = '0;
    repeat (2) tick();
    check("rst_oe", DATA_OE, 1'b0);
    check("rst_msg", msg_block, 128'd0);
    check("rst_rv", result_valid, 1'b0);
    RESET_N = 1'b1;
    tick();

    write_words(1'b0, '{32'h01234567, 32'h89abcdef,
                        32'hfedcba98, 32'h76543210});
    check("msg_load", msg_block, MSG1);
    write_words(1'b1, '{32'habcdefab, 32'h12345678, 32'h9abcdef0,
                        32'h0f1e2d3c, 32'hdeadbeef, 32'hcafef00d});
    check("key_saturate", key_block, KEY1);

    q_start.push_back('{1'b1, MSG1, KEY1});
    launch(1'b1);
    check("busy_wait", busy, 1'b1);
    write_words(1'b0, '{32'hffffffff});
    check("msg_frozen", msg_block, MSG1);

    finish_core(RES1);
    check("rv_after_done", result_valid, 1'b1);
    check("busy_after_done", busy, 1'b0);
    exp_words(RES1, 4);
    read(6);
    check("oe_after_read", DATA_OE, 1'b0);
    check("rv_after_read", result_valid, 1'b0);

    launch(1'b1);
    check("no_launch_busy", busy, 1'b0);

    write_words(1'b0, '{32'h11111111, 32'h22222222,
                        32'h33333333, 32'h44444444});
    q_start.push_back('{1'b0, MSG2, KEY1});
    launch(1'b0);
    check("relaunch_busy", busy, 1'b1);
    check("relaunch_cypher", core_cypher, 1'b0);

    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    finish_core(RES2);
    check("abort_rv", result_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cypher", core_cypher, 1'b0);
    check("abort_key", key_block, 128'd0);
    read(3);
    check("abort_read_oe", DATA_OE, 1'b0);

    // Address switch mid-burst restarts at word 0 of the new buffer.
    Initiate = 1'b1; Read_or_Write = 1'b1; Adress = 1'b0;
    DATA_IN = 32'haaaaaaaa; tick();
    DATA_IN = 32'hbbbbbbbb; tick();
    Adress = 1'b1;
    foreach (KEY1[i]) if (i % 32 == 0) begin
      DATA_IN = KEY1[i +: 32]; tick();
    end
    Adress = 1'b0;
    foreach (MSG2[i]) if (i % 32 == 0) begin
      DATA_IN = MSG2[i +: 32]; tick();
    end
    Initiate = 1'b0;
    tick();
    check("switch_key", key_block, KEY1);
    check("switch_msg", msg_block, MSG2);

    q_start.push_back('{1'b1, MSG2, KEY1});
    launch(1'b1);
    finish_core(RES2);
    exp_words(RES2, 2);
    read(2);
    check("early_drop_rv", result_valid, 1'b1);
    check("early_drop_oe", DATA_OE, 1'b0);
    exp_words(RES2, 4);
    read(5);
    check("reread_rv", result_valid, 1'b0);

    repeat (3) tick();
    check("start_q_empty", q_start.size(), 0);
    check("word_q_empty", q_word.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_bus_buffer.md
Name: aes_bus_buffer

Overview:
- Word-to-block bridge between the 32-bit chip bus (DATA, Initiate, Read_or_Write, Adress) and the AES128 core.
- Assembles four bus words into 128-bit message and key registers, and issues a one-cycle start to the core.
- Captures the 128-bit core result and streams it back onto the bus as four words.
- Sits directly upstream and downstream of the AES round datapath inside the chip top.

Parameters:
WORD_W, 32, bus word width
WORDS, 4, words per 128-bit block (WORD_W*WORDS = 128)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
Initiate  in  1  bus transfer enable
Read_or_Write  in  1  1 = bus write into block, 0 = bus read of result
Adress  in  1  write target: 0 = message buffer, 1 = key buffer
SelCypher  in  1  1 = encrypt, 0 = decrypt; sampled on Start
Start  in  1  launch request, single-cycle pulse
DATA_IN  in  [0:31]  bus write data (pad input side)
DATA_OUT  out  [0:31]  bus read data (pad output side)
DATA_OE  out  1  pad output enable; 1 = block drives the bus
msg_block  out  [0:127]  assembled message to core
key_block  out  [0:127]  assembled key to core
core_start  out  1  one-cycle launch pulse to core
core_cypher  out  1  mode latched at launch
core_done  in  1  one-cycle pulse: core_result valid
core_result  in  [0:127]  core output block
busy  out  1  core operation in flight
result_valid  out  1  unread result available

Behaviour:
- Reset (async, RESET_N=0):
  - All outputs 0; DATA_OE=0; msg_block/key_block 0.
  - Word counter 0; msg_valid/key_valid 0; state IDLE.
  - Assertion mid-operation aborts everything; a later core_done is ignored until a new launch.
- States: IDLE, LOAD, WAIT_CORE, UNLOAD.
- IDLE -> LOAD when Initiate=1 & Read_or_Write=1 & busy=0:
  - In that same cycle the first word is captured into word 0, i.e. bits [0:31] of the buffer selected by Adress.
- LOAD:
  - Each cycle with Initiate=1 & Read_or_Write=1, DATA_IN goes to word[cnt] (word k = bits [32k : 32k+31]) and cnt increments.
  - After the 4th word: the buffer's valid flag is set; cnt saturates at 4; further words are ignored (no wrap, no overwrite).
  - A change of Adress while Initiate=1 resets cnt to 0; the new word is taken as word 0 of the new buffer.
  - Initiate=0 -> IDLE with cnt=0.
  - A partial load (fewer than 4 words) leaves that buffer's valid flag at 0 but keeps the words already written.
- Launch:
  - Condition: Start=1 & Initiate=0 & state IDLE & msg_valid & key_valid.
  - Next cycle: core_start=1 for exactly one cycle; core_cypher=SelCypher sampled with Start; busy=1; state WAIT_CORE; msg_valid cleared.
  - key_valid is retained, so the key is reusable across operations.
  - Start under any other condition is ignored; no queuing.
- WAIT_CORE:
  - Bus writes are ignored; msg_block/key_block are frozen.
  - On core_done: result register <= core_result, busy=0, result_valid=1, state IDLE.
- IDLE -> UNLOAD when Initiate=1 & Read_or_Write=0 & result_valid=1:
  - Registered output: DATA_OE=1 and DATA_OUT=result word 0 in the following cycle, then words 1, 2, 3 on successive cycles while Initiate stays 1.
  - After word 3, DATA_OE drops the next cycle, result_valid=0, state IDLE.
  - Initiate dropping early gives DATA_OE=0 the next cycle; result_valid stays 1 and the next read restarts at word 0.
- Read with result_valid=0: DATA_OE stays 0 (bus remains high-Z) and state is unchanged.
- DATA_OE is never 1 while Read_or_Write=1 is sampled (no bus contention).
- A new core_done while result_valid=1 overwrites the result.

Decomposition:
- Package aes_bus_pkg:
  - Localparams WORD_W, WORDS, BLOCK_W=128.
  - State enum typedef.
  - Word/block typedefs ([0:31], [0:127]).
- One sub-module: aes_word_packer, a 4x32 shift/index register with saturating counter and valid flag.
  - Instantiated twice (message, key).
  - Unload path stays in the top.

Test Plan:
- Write 4 words 01234567, 89abcdef, fedcba98, 76543210 with Adress=0 -> msg_block=0123456789abcdeffedcba9876543210, msg_valid=1.
- Write 6 words abcdefab..., Adress=1 -> key_block holds the first 4 words only; words 5-6 are ignored.
- Pulse Start with SelCypher=1 after both loads -> core_start high exactly 1 cycle, core_cypher=1, busy=1.
- Stub core_done with result 00112233_44556677_8899aabb_ccddeeff; read with RW=0 -> DATA_OE=1 for 4 cycles, DATA_OUT=00112233, 44556677, 8899aabb, ccddeeff, then OE=0 and result_valid=0.
- Reload message only, Start with SelCypher=0 -> launch occurs using the retained key, core_cypher=0; Start before the message is reloaded -> no core_start.
- Assert RESET_N=0 during WAIT_CORE, then pulse core_done -> all outputs 0, result_valid stays 0, DATA_OE=0.
